csm_shared_mem: RTL and testbench

- Responder end of the CSM port protocol: two-port (A, B) shared memory with per-address hold/release locking.
- Accepts read, write, hold and release operations on each port.
- Returns read data plus an error flag, and enforces lock ownership between the ports.
- This is the DUT behind CSM_bfm: the BFM drives its request ports and samples its responses.

---
 rtl/csm_pkg.sv | 31 +++
 rtl/csm_lock_table.sv | 95 +++++++++
 rtl/csm_shared_mem.sv | 127 ++++++++++++
 tb/tb_csm_shared_mem.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/csm_pkg.sv
// Shared types and default sizes for the CSM two-port shared memory.
package csm_pkg;

  localparam int ADDR_W_DEF       = 3;
  localparam int DATA_W_DEF       = 8;
  localparam int HOLD_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_HOLD    = 2'd2,
    OP_RELEASE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } port_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } resp_t;

endpackage

// File: rtl/csm_lock_table.sv
// Per-address lock ownership with hold timeout and port-A-first arbitration.
module csm_lock_table
  import csm_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_acc,
  input  logic [1:0]        a_op,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_acc,
  input  logic [1:0]        b_op,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_grant,
  output logic              a_err,
  output logic              b_grant,
  output logic              b_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  owner_t           owner_reg [DEPTH];
  logic [CNT_W-1:0] cnt_reg   [DEPTH];

  op_t    a_op_e, b_op_e;
  owner_t a_own, a_own_next, b_own;
  logic   same_addr;
  logic [DEPTH-1:0] a_sel, b_sel;

  assign a_op_e = op_t'(a_op);
  assign b_op_e = op_t'(b_op);

  // B is judged against the lock state after A's effect on a shared address.
  always_comb begin
    a_own      = owner_reg[a_addr];
    a_err      = a_acc && ((a_own == OWN_B) || ((a_op_e == OP_RELEASE) && (a_own != OWN_A)));
    a_grant    = a_acc && !a_err;
    a_own_next = a_own;
    if (a_grant && (a_op_e == OP_HOLD))    a_own_next = OWN_A;
    if (a_grant && (a_op_e == OP_RELEASE)) a_own_next = NONE;
    same_addr  = a_acc && (a_addr == b_addr);
    b_own      = same_addr ? a_own_next : owner_reg[b_addr];
    b_err      = b_acc && ((b_own == OWN_A) ||
                           ((b_op_e == OP_RELEASE) && (b_own != OWN_B)) ||
                           (same_addr && a_grant && (a_op_e == OP_WRITE) && (b_op_e == OP_WRITE)));
    b_grant    = b_acc && !b_err;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign a_sel[gi] = a_grant && (a_addr == ADDR_W'(gi));
      assign b_sel[gi] = b_grant && (b_addr == ADDR_W'(gi));
    end
  endgenerate

  // Expiry first; an accepted HOLD/RELEASE in the same cycle overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        owner_reg[i] <= NONE;
        cnt_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((HOLD_TIMEOUT > 0) && (owner_reg[i] != NONE)) begin
          if (cnt_reg[i] <= CNT_W'(1)) begin
            owner_reg[i] <= NONE;
            cnt_reg[i]   <= '0;
          end else begin
            cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
          end
        end
        if (a_sel[i] && (a_op_e == OP_HOLD)) begin
          owner_reg[i] <= OWN_A;
          cnt_reg[i]   <= CNT_W'(HOLD_TIMEOUT);
        end else if (a_sel[i] && (a_op_e == OP_RELEASE)) begin
          owner_reg[i] <= NONE;
          cnt_reg[i]   <= '0;
        end
        if (b_sel[i] && (b_op_e == OP_HOLD)) begin
          owner_reg[i] <= OWN_B;
          cnt_reg[i]   <= CNT_W'(HOLD_TIMEOUT);
        end else if (b_sel[i] && (b_op_e == OP_RELEASE)) begin
          owner_reg[i] <= NONE;
          cnt_reg[i]   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/csm_shared_mem.sv
// Two-port shared memory responder: memory array, per-port request FSMs, lock table.
module csm_shared_mem
  import csm_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [1:0]        a_op,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_valid,
  input  logic [1:0]        b_op,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [1:0]        valid_in, ready, done, acc, err_in, err_out;
  logic [1:0]        op_in     [2];
  logic [ADDR_W-1:0] addr_in   [2];
  logic [DATA_W-1:0] rdata_out [2];
  logic              a_grant, a_lock_err, b_grant, b_lock_err;

  assign valid_in   = {b_valid, a_valid};
  assign op_in[0]   = a_op;
  assign op_in[1]   = b_op;
  assign addr_in[0] = a_addr;
  assign addr_in[1] = b_addr;
  assign acc        = valid_in & ready;
  assign err_in     = {b_lock_err, a_lock_err};

  csm_lock_table #(
    .ADDR_W      (ADDR_W),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_lock (
    .clk    (clk),
    .reset  (reset),
    .a_acc  (acc[0]),
    .a_op   (a_op),
    .a_addr (a_addr),
    .b_acc  (acc[1]),
    .b_op   (b_op),
    .b_addr (b_addr),
    .a_grant(a_grant),
    .a_err  (a_lock_err),
    .b_grant(b_grant),
    .b_err  (b_lock_err)
  );

  // Same-address double writes never reach here: the lock table rejects B's.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (a_grant && (op_t'(a_op) == OP_WRITE)) mem_reg[a_addr] <= a_wdata;
      if (b_grant && (op_t'(b_op) == OP_WRITE)) mem_reg[b_addr] <= b_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      port_state_t       state_reg, state_next;
      logic              ready_l, done_l, err_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          ST_IDLE: if (acc[gi]) state_next = ST_RESP;
          ST_RESP: state_next = ST_IDLE;
          default: state_next = ST_IDLE;
        endcase
      end

      // A response still pending when reset arrives is suppressed.
      always_comb begin
        ready_l = (state_reg == ST_IDLE);
        done_l  = (state_reg == ST_RESP) && !reset;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end else if (acc[gi]) begin
          err_reg   <= err_in[gi];
          rdata_reg <= (!err_in[gi] && (op_t'(op_in[gi]) == OP_READ)) ? mem_reg[addr_in[gi]] : '0;
        end
      end

      assign ready[gi]     = ready_l;
      assign done[gi]      = done_l;
      assign err_out[gi]   = err_reg;
      assign rdata_out[gi] = rdata_reg;
    end
  endgenerate

  assign a_ready = ready[0];
  assign a_done  = done[0];
  assign a_rdata = rdata_out[0];
  assign a_err   = err_out[0];
  assign b_ready = ready[1];
  assign b_done  = done[1];
  assign b_rdata = rdata_out[1];
  assign b_err   = err_out[1];

endmodule

// File: tb/tb_csm_shared_mem.sv
// Directed and randomized checks of csm_shared_mem against a cycle-stamped lock/memory model.
module tb_csm_shared_mem;

  localparam int TO = 16;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, HD = 2'd2, RL = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid;
  logic [1:0] a_op, b_op;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, a_done, a_err, b_ready, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;

  csm_shared_mem #(.ADDR_W(3), .DATA_W(8), .HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: memory contents, owner (0 none, 1 A, 2 B) and the edge of the last successful HOLD.
  logic [7:0] mem_m   [8];
  int         owner_m [8];
  int         hold_m  [8];
  logic [7:0] last_a_rdata, last_b_rdata;
  logic       last_a_err, last_b_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mem_m[i]   = 8'h00;
      owner_m[i] = 0;
      hold_m[i]  = 0;
    end
  endtask

  // A hold taken at edge h is honoured for requests accepted up to edge h+TO.
  function automatic int eff_owner(input int addr, input int e);
    if (owner_m[addr] != 0 && (e - hold_m[addr]) <= TO) return owner_m[addr];
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge with both ports idle; takes two cycles.
  task automatic txn(input bit av, input logic [1:0] aop, input logic [2:0] aad, input logic [7:0] awd,
                     input bit bv, input logic [1:0] bop, input logic [2:0] bad, input logic [7:0] bwd);
    int e, oa, ob, after;
    bit ea, eb;
    logic [7:0] ra, rb;
    e  = cyc + 1;
    oa = eff_owner(aad, e);
    ea = av && (oa == 2 || (aop == RL && oa != 1));
    after = oa;
    if (av && !ea && aop == HD) after = 1;
    if (av && !ea && aop == RL) after = 0;
    ob = (av && aad == bad) ? after : eff_owner(bad, e);
    eb = bv && (ob == 1 || (bop == RL && ob != 2) ||
                (av && !ea && aad == bad && aop == WR && bop == WR));
    ra = (av && !ea && aop == RD) ? mem_m[aad] : 8'h00;
    rb = (bv && !eb && bop == RD) ? mem_m[bad] : 8'h00;
    if (av && !ea) begin
      if (aop == WR) mem_m[aad] = awd;
      if (aop == HD) begin owner_m[aad] = 1; hold_m[aad] = e; end
      if (aop == RL) owner_m[aad] = 0;
    end
    if (bv && !eb) begin
      if (bop == WR) mem_m[bad] = bwd;
      if (bop == HD) begin owner_m[bad] = 2; hold_m[bad] = e; end
      if (bop == RL) owner_m[bad] = 0;
    end

    check("a_ready_idle", a_ready, 1);
    check("b_ready_idle", b_ready, 1);
    check("a_done_idle", a_done, 0);
    check("b_done_idle", b_done, 0);
    a_valid = av; a_op = aop; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_op = bop; b_addr = bad; b_wdata = bwd;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check("a_done", a_done, av);
    check("b_done", b_done, bv);
    check("a_ready_resp", a_ready, !av);
    check("b_ready_resp", b_ready, !bv);
    if (av) begin
      check("a_err", a_err, ea);
      check("a_rdata", a_rdata, ra);
    end
    if (bv) begin
      check("b_err", b_err, eb);
      check("b_rdata", b_rdata, rb);
    end
    last_a_rdata = a_rdata; last_a_err = a_err;
    last_b_rdata = b_rdata; last_b_err = b_err;
    $display("[TB] e=%0d A v=%0b op=%0d addr=%0d wd=%02h -> err=%0b rd=%02h | B v=%0b op=%0d addr=%0d wd=%02h -> err=%0b rd=%02h",
             e, av, aop, aad, awd, a_err, a_rdata, bv, bop, bad, bwd, b_err, b_rdata);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_op = RD; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_op = RD; b_addr = '0; b_wdata = '0;
    model_reset();
    idle(3);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_err", b_err, 0);
    reset = 1'b0;
    idle(1);

    // Basic write/read
    txn(1, WR, 3, 8'hA5, 0, RD, 0, 8'h00);
    check("wr3_err", last_a_err, 0);
    txn(1, RD, 3, 8'h00, 0, RD, 0, 8'h00);
    check("rd3_data", last_a_rdata, 8'hA5);

    // Hold blocks the other port
    txn(1, HD, 2, 8'h00, 0, RD, 0, 8'h00);
    txn(0, RD, 0, 8'h00, 1, RD, 2, 8'h00);
    check("b_rd_held_err", last_b_err, 1);
    txn(0, RD, 0, 8'h00, 1, WR, 2, 8'h11);
    check("b_wr_held_err", last_b_err, 1);
    txn(1, RD, 2, 8'h00, 0, RD, 0, 8'h00);
    check("a_rd2_prior", last_a_rdata, 8'h00);
    txn(1, RL, 2, 8'h00, 0, RD, 0, 8'h00);

    // Hold/release then free access
    txn(1, HD, 5, 8'h00, 0, RD, 0, 8'h00);
    txn(1, RL, 5, 8'h00, 0, RD, 0, 8'h00);
    txn(0, RD, 0, 8'h00, 1, WR, 5, 8'hFF);
    txn(0, RD, 0, 8'h00, 1, RD, 5, 8'h00);
    check("b_rd5_data", last_b_rdata, 8'hFF);
    txn(0, RD, 0, 8'h00, 1, RL, 5, 8'h00);
    check("b_rl_unheld_err", last_b_err, 1);

    // Simultaneous writes to the same address
    txn(1, WR, 1, 8'h00, 1, WR, 1, 8'h3C);
    check("dual_wr_a_err", last_a_err, 0);
    check("dual_wr_b_err", last_b_err, 1);
    txn(1, RD, 1, 8'h00, 0, RD, 0, 8'h00);
    check("rd1_after_dual", last_a_rdata, 8'h00);

    // Hold timeout: held at +15, free at +17
    txn(1, HD, 7, 8'h00, 0, RD, 0, 8'h00);
    idle(13);
    txn(0, RD, 0, 8'h00, 1, WR, 7, 8'h55);
    check("to_plus15_err", last_b_err, 1);
    txn(0, RD, 0, 8'h00, 1, WR, 7, 8'h55);
    check("to_plus17_err", last_b_err, 0);
    txn(1, RD, 7, 8'h00, 0, RD, 0, 8'h00);
    check("rd7_after_to", last_a_rdata, 8'h55);

    // Reset while a READ response is pending
    a_valid = 1'b1; a_op = RD; a_addr = 3'd3;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_pending_done", a_done, 0);
    @(negedge clk);
    check("rst_after_ready", a_ready, 1);
    check("rst_after_done", a_done, 0);
    reset = 1'b0;
    model_reset();
    txn(1, RD, 3, 8'h00, 0, RD, 0, 8'h00);
    check("rd3_after_rst", last_a_rdata, 8'h00);

    // Randomized traffic on a small address window to force collisions
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 18));
      txn(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 8'($urandom),
          ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
